// File: rtl/mmul_sched.sv
// Round-robin scheduler that shares one registered 9x9/3x3 multiplier between two requesters and queues tagged results.
// Optional operation counter: define MMUL_SCHED_STATS_EN to build stat_ops. Without it, stat_ops is tied to 0.
module mmul_sched #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [1:0]  req0_mode,
  input  logic [8:0]  req0_d,
  input  logic [8:0]  req0_w1,
  input  logic [8:0]  req0_w2,
  input  logic [8:0]  req0_w3,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [1:0]  req1_mode,
  input  logic [8:0]  req1_d,
  input  logic [8:0]  req1_w1,
  input  logic [8:0]  req1_w2,
  input  logic [8:0]  req1_w3,
  output logic [8:0]  mm_d,
  output logic [8:0]  mm_w1,
  output logic [8:0]  mm_w2,
  output logic [8:0]  mm_w3,
  output logic [1:0]  mm_convtype,
  input  logic [15:0] mm_mul,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic        rsp_err,
  output logic [15:0] rsp_data,
  output logic [31:0] stat_ops
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic        id;
    logic        err;
    logic [15:0] data;
  } rsp_t;

  logic          ptr;
  logic          v1, id1, err1;
  logic          v2, id2, err2;
  rsp_t          mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] inflight;
  logic          credit_ok;
  logic          grant0, grant1;
  logic          accept, sel;
  logic [1:0]    mode;
  logic [8:0]    d, w1, w2, w3;
  logic          push, pop;

  // Credit counts only registered occupancy, so a same-cycle pop never frees a slot early.
  assign inflight  = CW'(v1) + CW'(v2) + count;
  assign credit_ok = inflight < CW'(FIFO_DEPTH);

  assign grant0     = req0_valid & (~req1_valid | ~ptr);
  assign grant1     = req1_valid & (~req0_valid | ptr);
  assign req0_ready = grant0 & credit_ok;
  assign req1_ready = grant1 & credit_ok;

  assign accept = (req0_valid & req0_ready) | (req1_valid & req1_ready);
  assign sel    = req1_valid & req1_ready;
  assign mode   = sel ? req1_mode : req0_mode;
  assign d      = sel ? req1_d    : req0_d;
  assign w1     = sel ? req1_w1   : req0_w1;
  assign w2     = sel ? req1_w2   : req0_w2;
  assign w3     = sel ? req1_w3   : req0_w3;

  // Operands only load on accept so idle cycles leave the multiplier inputs quiet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr         <= 1'b0;
      v1          <= 1'b0;
      id1         <= 1'b0;
      err1        <= 1'b0;
      v2          <= 1'b0;
      id2         <= 1'b0;
      err2        <= 1'b0;
      mm_d        <= '0;
      mm_w1       <= '0;
      mm_w2       <= '0;
      mm_w3       <= '0;
      mm_convtype <= 2'b00;
    end else begin
      v1   <= accept;
      v2   <= v1;
      id2  <= id1;
      err2 <= err1;
      if (accept) begin
        ptr   <= ~sel;
        id1   <= sel;
        err1  <= mode[1];
        mm_d  <= d;
        mm_w1 <= w1;
        if (mode == 2'b01) begin
          mm_convtype <= 2'b01;
          mm_w2       <= w2;
          mm_w3       <= w3;
        end else begin
          mm_convtype <= 2'b00;
          mm_w2       <= w1;
          mm_w3       <= w1;
        end
      end
    end
  end

  assign push = v2;
  assign pop  = rsp_valid & rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{id: id2, err: err2, data: mm_mul};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
    end
  end

  assign rsp_valid = (count != '0);
  assign rsp_id    = mem[rd_ptr].id;
  assign rsp_err   = mem[rd_ptr].err;
  assign rsp_data  = mem[rd_ptr].data;

`ifdef MMUL_SCHED_STATS_EN
  logic [31:0] ops_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ops_q <= '0;
    else if (accept) ops_q <= ops_q + 32'd1;
  end
  assign stat_ops = ops_q;
`else
  assign stat_ops = '0;
`endif

endmodule
